// File: rtl/fetch_pkg.sv
// Shared types and ARF control encodings for the two-byte instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ_LO = 3'd1,
    INC_LO = 3'd2,
    REQ_HI = 3'd3,
    INC_HI = 3'd4,
    DONE   = 3'd5
  } state_e;

  localparam logic [2:0] FUNSEL_INC  = 3'b001;
  localparam logic [2:0] FUNSEL_HOLD = 3'b000;
  localparam logic [2:0] REGSEL_PC   = 3'b011;
  localparam logic [2:0] REGSEL_NONE = 3'b111;
  localparam logic [1:0] OUTDSEL_PC  = 2'b00;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts consecutive wait cycles; expired_o pulses on the WAIT_MAX-th counted cycle (never when WAIT_MAX is 0).
module fetch_timeout_counter #(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'((WAIT_MAX == 0) ? 0 : WAIT_MAX - 1);
  localparam bit ENABLED = (WAIT_MAX != 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = ENABLED && en_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Fetches a little-endian 16-bit instruction at PC over an 8-bit ready/valid memory port,
// steering the ARF to increment PC after each byte and pulsing ir_valid_o when IR is complete.
module instr_fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic        mem_ready_i,
  input  logic [7:0]  mem_data_i,
  output logic        mem_read_o,
  output logic [1:0]  out_d_sel_o,
  output logic [2:0]  arf_fun_sel_o,
  output logic [2:0]  arf_reg_sel_o,
  output logic [15:0] ir_o,
  output logic        ir_valid_o,
  output logic        busy_o,
  output logic        error_o,
  output state_e      state_o
);

  // Handshake: a byte transfers on any rising edge where mem_read_o and mem_ready_i are both high;
  // mem_read_o holds until that edge (or a flush/timeout) and mem_data_i is sampled on it.

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        err_q, err_d;
  logic        in_req;
  logic        cnt_en, cnt_clear, expired;

  assign in_req    = (state_q == REQ_LO) || (state_q == REQ_HI);
  assign cnt_en    = in_req && !mem_ready_i && !flush_i;
  assign cnt_clear = !cnt_en;

  fetch_timeout_counter #(
    .WAIT_MAX(WAIT_MAX),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (cnt_clear),
    .en_i     (cnt_en),
    .expired_o(expired)
  );

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          err_d   = 1'b0;
          state_d = REQ_LO;
        end
      end
      REQ_LO: begin
        if (mem_ready_i) begin
          ir_d[7:0] = mem_data_i;
          state_d   = INC_LO;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      INC_LO: state_d = REQ_HI;
      REQ_HI: begin
        if (mem_ready_i) begin
          ir_d[15:8] = mem_data_i;
          state_d    = INC_HI;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      INC_HI: state_d = DONE;
      DONE: begin
        if (start_i) begin
          err_d   = 1'b0;
          state_d = REQ_LO;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over capture, timeout and start alike.
    if (flush_i) begin
      state_d = IDLE;
      ir_d    = ir_q;
      err_d   = err_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ir_q    <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  assign mem_read_o    = in_req;
  assign out_d_sel_o   = OUTDSEL_PC;
  assign arf_reg_sel_o = ((state_q == INC_LO) || (state_q == INC_HI)) ? REGSEL_PC : REGSEL_NONE;
  assign arf_fun_sel_o = ((state_q == INC_LO) || (state_q == INC_HI)) ? FUNSEL_INC : FUNSEL_HOLD;
  assign ir_valid_o    = (state_q == DONE);
  assign busy_o        = (state_q != IDLE);
  assign ir_o          = ir_q;
  assign error_o       = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench: byte-wide memory and ARF PC model around the fetch sequencer, IR scoreboard on ir_valid_o.
module tb_instr_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, flush_i, mem_ready_i;
  logic [7:0]  mem_data_i;
  logic        mem_read_o, ir_valid_o, busy_o, error_o;
  logic [1:0]  out_d_sel_o;
  logic [2:0]  arf_fun_sel_o, arf_reg_sel_o;
  logic [15:0] ir_o;
  state_e      state_o;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  logic [7:0]  mem [0:255];
  logic [15:0] pc_m = 16'h0020;
  int          inc_cnt = 0;
  int          valid_cnt = 0;
  int          ready_wait = 0;
  int          wait_cnt = 0;
  bit          ready_never = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  instr_fetch_sequencer #(.WAIT_MAX(16), .CNT_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .flush_i      (flush_i),
    .mem_ready_i  (mem_ready_i),
    .mem_data_i   (mem_data_i),
    .mem_read_o   (mem_read_o),
    .out_d_sel_o  (out_d_sel_o),
    .arf_fun_sel_o(arf_fun_sel_o),
    .arf_reg_sel_o(arf_reg_sel_o),
    .ir_o         (ir_o),
    .ir_valid_o   (ir_valid_o),
    .busy_o       (busy_o),
    .error_o      (error_o),
    .state_o      (state_o)
  );

  // ARF model: PC increments on the same edge the sequencer presents the INC controls.
  always @(posedge clk) begin
    if (rst_n && arf_reg_sel_o == 3'b011 && arf_fun_sel_o == 3'b001) begin
      pc_m    <= pc_m + 16'd1;
      inc_cnt <= inc_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (ir_valid_o === 1'b1) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_ir_valid", 32'(ir_o), 32'hFFFF_FFFF);
      end else begin
        chk("ir_word", 32'(ir_o), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    mem_data_i = mem[pc_m[7:0]];
    if (mem_read_o && !ready_never && wait_cnt >= ready_wait) begin
      mem_ready_i = 1'b1;
      wait_cnt    = 0;
    end else begin
      mem_ready_i = 1'b0;
      if (mem_read_o) wait_cnt++;
    end
  endtask

  // Caller raises start_i; returns edges from the Start-sampling edge to ir_valid_o visible.
  task automatic fetch_latency(output int n);
    n = 0;
    do begin
      step();
      n++;
      start_i = 1'b0;
    end while (ir_valid_o !== 1'b1 && n < 40);
    chk("fetch_no_timeout", 32'(n < 40), 32'd1);
  endtask

  initial begin : main
    int n, inc0, v0, first_v, second_v;
    logic [15:0] pc0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h20] = 8'h34; mem[8'h21] = 8'h12;
    mem[8'h22] = 8'hCD; mem[8'h23] = 8'hAB;
    mem[8'h24] = 8'h78; mem[8'h25] = 8'h56;
    mem[8'h26] = 8'h11; mem[8'h27] = 8'hEE;
    mem[8'h28] = 8'h22; mem[8'h29] = 8'h33;
    mem[8'h2A] = 8'h44; mem[8'h2B] = 8'h55;
    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0; mem_ready_i = 1'b0; mem_data_i = 8'h00;
    step(); step();
    chk("rst_state", 32'(state_o), 32'(IDLE));
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_mem_read", 32'(mem_read_o), 32'd0);
    chk("rst_regsel", 32'(arf_reg_sel_o), 32'h7);
    chk("rst_funsel", 32'(arf_fun_sel_o), 32'h0);
    chk("rst_ir", 32'(ir_o), 32'h0);
    chk("rst_err", 32'(error_o), 32'd0);
    chk("rst_valid", 32'(ir_valid_o), 32'd0);
    chk("outd_sel", 32'(out_d_sel_o), 32'h0);
    rst_n = 1'b1;
    step();

    // Normal fetch, memory always ready.
    inc0 = inc_cnt; v0 = valid_cnt;
    exp_q.push_back(16'h1234);
    start_i = 1'b1;
    fetch_latency(n);
    chk("normal_latency", 32'(n), 32'd5);
    step();
    chk("normal_pulse_once", 32'(valid_cnt - v0), 32'd1);
    chk("normal_incs", 32'(inc_cnt - inc0), 32'd2);
    chk("normal_pc", 32'(pc_m), 32'h0022);
    chk("normal_idle", 32'(state_o), 32'(IDLE));

    // Three wait cycles ahead of each byte.
    ready_wait = 3; inc0 = inc_cnt;
    exp_q.push_back(16'hABCD);
    start_i = 1'b1;
    fetch_latency(n);
    chk("wait_latency", 32'(n), 32'd11);
    chk("wait_err", 32'(error_o), 32'd0);
    step();
    chk("wait_pc", 32'(pc_m), 32'h0024);

    // Timeout in REQ_LO.
    ready_never = 1'b1; ready_wait = 0; inc0 = inc_cnt;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("to_still_waiting", 32'(state_o), 32'(REQ_LO));
    chk("to_err_not_yet", 32'(error_o), 32'd0);
    step();
    chk("to_state", 32'(state_o), 32'(IDLE));
    chk("to_err", 32'(error_o), 32'd1);
    chk("to_busy", 32'(busy_o), 32'd0);
    chk("to_no_inc", 32'(inc_cnt - inc0), 32'd0);
    chk("to_pc", 32'(pc_m), 32'h0024);
    ready_never = 1'b0;
    exp_q.push_back(16'h5678);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("to_err_cleared", 32'(error_o), 32'd0);
    n = 0;
    while (ir_valid_o !== 1'b1 && n < 40) begin step(); n++; end
    chk("to_refetch_latency", 32'(n + 1), 32'd5);
    step();

    // Flush in REQ_HI with same-cycle MemReady.
    inc0 = inc_cnt; v0 = valid_cnt;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step(); step();
    chk("fl_in_req_hi", 32'(state_o), 32'(REQ_HI));
    chk("fl_ready_same_cycle", 32'(mem_ready_i), 32'd1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("fl_idle", 32'(state_o), 32'(IDLE));
    chk("fl_ir", 32'(ir_o), 32'h5611);
    step(); step(); step();
    chk("fl_no_valid", 32'(valid_cnt - v0), 32'd0);
    chk("fl_one_inc", 32'(inc_cnt - inc0), 32'd1);
    chk("fl_pc", 32'(pc_m), 32'h0027);

    // Back-to-back with Start held high.
    inc0 = inc_cnt; pc0 = pc_m;
    exp_q.push_back(16'h22EE);
    exp_q.push_back(16'h4433);
    start_i = 1'b1;
    first_v = 0; second_v = 0;
    for (int i = 1; i <= 30 && second_v == 0; i++) begin
      step();
      if (ir_valid_o === 1'b1) begin
        if (first_v == 0) first_v = i;
        else begin
          second_v = i;
          start_i  = 1'b0;
        end
      end else if (first_v != 0 && i == first_v + 1) begin
        chk("b2b_req_after_done", 32'(state_o), 32'(REQ_LO));
      end
    end
    start_i = 1'b0;
    chk("b2b_first", 32'(first_v), 32'd5);
    chk("b2b_spacing", 32'(second_v - first_v), 32'd5);
    step();
    chk("b2b_idle", 32'(state_o), 32'(IDLE));
    chk("b2b_pc", 32'(pc_m - pc0), 32'd4);
    chk("b2b_incs", 32'(inc_cnt - inc0), 32'd4);

    // Asynchronous reset mid REQ_HI.
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step(); step();
    chk("mr_in_req_hi", 32'(state_o), 32'(REQ_HI));
    rst_n = 1'b0;
    #1;
    chk("mr_state", 32'(state_o), 32'(IDLE));
    chk("mr_busy", 32'(busy_o), 32'd0);
    chk("mr_mem_read", 32'(mem_read_o), 32'd0);
    chk("mr_ir", 32'(ir_o), 32'h0);
    chk("mr_regsel", 32'(arf_reg_sel_o), 32'h7);
    step();
    rst_n = 1'b1;
    step();
    chk("mr_busy_after", 32'(busy_o), 32'd0);
    chk("mr_regsel_after", 32'(arf_reg_sel_o), 32'h7);
    chk("mr_pc_kept", 32'(pc_m - pc0), 32'd5);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
